pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 32: refclk cycles pll_rst is held high per reset attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 256: consecutive synced-lock cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 50000 (1 ms at 50 MHz): maximum wait for lock per attempt.
REQ-004 SHALL have parameter MAX_RETRIES, default 4: consecutive timeouts tolerated (used only under PLL_SEQ_RETRY_LIMIT_EN).
REQ-005 refclk  input  1  50 MHz reference clock; sole clock of the block.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 pll_locked  input  1  PLL lock flag, asynchronous to refclk.
REQ-008 pll_rst  output  1  drives PLL reset, active-high.
REQ-009 core_rst  output  1  active-high reset for downstream core, refclk domain.
REQ-010 ready  output  1  high only in RUN.
REQ-011 fail  output  1  sticky PLL failure flag.
REQ-012 relock_count  output  8  saturating count of re-entries into RESET_HOLD.

Function
REQ-013 SHALL synchronise pll_locked through two refclk flops (lock_s); no other path SHALL use pll_locked.
REQ-014 SHALL implement FSM states RESET_HOLD, WAIT_LOCK, STABLE, RUN, FAIL.
REQ-015 RESET_HOLD: pll_rst=1, core_rst=1; SHALL move to WAIT_LOCK after exactly RST_HOLD_CYCLES cycles in state.
REQ-016 WAIT_LOCK: pll_rst=0, core_rst=1; lock_s=1 -> STABLE; LOCK_TIMEOUT_CYCLES cycles elapsed without lock_s -> RESET_HOLD (timeout).
REQ-017 STABLE: lock_s=0 -> WAIT_LOCK with timeout counter restarted; lock_s=1 for LOCK_STABLE_CYCLES consecutive cycles -> RUN.
REQ-018 RUN: pll_rst=0, core_rst=0, ready=1; lock_s=0 -> RESET_HOLD (lock loss).
REQ-019 With pll_locked stable high, ready SHALL rise exactly LOCK_STABLE_CYCLES+3 cycles after the first refclk edge sampling pll_locked=1 in WAIT_LOCK.
REQ-020 core_rst SHALL assert in the same cycle ready falls (combinational from state register, no extra latency) and deassert with ready.
REQ-021 relock_count SHALL increment on every timeout and lock-loss transition, saturating at 255; timeout and lock loss never coincide.
REQ-022 One state counter, width clog2 of largest parameter, SHALL be cleared on every state transition.
REQ-023 A consecutive-timeout counter SHALL clear on entry to RUN.

Reset
REQ-024 While rst=1, asynchronously: state=RESET_HOLD, pll_rst=1, core_rst=1, ready=0, fail=0, relock_count=0, sync flops=0, all counters=0.
REQ-025 rst asserted mid-operation SHALL abort any state immediately; RESET_HOLD restarts a full RST_HOLD_CYCLES on deassertion.

Configuration
REQ-026 Macro PLL_SEQ_RETRY_LIMIT_EN defined: the MAX_RETRIES-th consecutive timeout SHALL enter FAIL (pll_rst=1, core_rst=1, fail=1), exited only by rst.
REQ-027 Macro undefined: retries unlimited, FAIL unreachable, fail tied to 0.

Structure
REQ-028 Package pll_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-029 The two-flop synchroniser SHALL be sub-module sync_2ff (1-bit, reset to 0).

Verification (RST_HOLD=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2)
REQ-030 Release rst, pll_locked high from cycle 0 -> pll_rst high 4 cycles, then ready=1 and core_rst=0 exactly 11 cycles after first lock sample.
REQ-031 pll_locked pulses low 1 cycle during STABLE -> back to WAIT_LOCK, ready only after 8 fresh consecutive lock cycles, relock_count=0.
REQ-032 pll_locked drops in RUN -> ready=0, core_rst=1 within 3 cycles, pll_rst=1 for 4 cycles, relock_count=1.
REQ-033 pll_locked held low, macro defined -> two 32-cycle timeouts, fail=1, pll_rst=1 permanently, relock_count=2; without macro -> endless retries, fail=0, relock_count saturates at 255.
REQ-034 rst asserted in RUN and in WAIT_LOCK -> all outputs at reset values same cycle; full sequence repeats after release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// Optional feature macro: PLL_SEQ_RETRY_LIMIT_EN (bounded retries, sticky FAIL).
package pll_seq_pkg;

  localparam int DEF_RST_HOLD_CYCLES     = 32;
  localparam int DEF_LOCK_STABLE_CYCLES  = 256;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_MAX_RETRIES         = 4;

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } seq_state_e;

  // Width of the shared state counter. It must also hold LOCK_STABLE_CYCLES
  // itself (STABLE counts one extra edge), hence max+1.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Saturating increment for the 8-bit relock counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops; both clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so q takes the old meta value; with
      // blocking assignments the two flops would collapse into one.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer clocked by refclk.
// Optional feature macro: PLL_SEQ_RETRY_LIMIT_EN -- when defined, the
// MAX_RETRIES-th consecutive lock timeout parks the block in FAIL until rst.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] relock_count
);

  localparam int CW = cnt_width(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES,
                                LOCK_TIMEOUT_CYCLES, MAX_RETRIES);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);
  // STABLE leaves on the edge after LOCK_STABLE_CYCLES qualified edges,
  // giving LOCK_STABLE_CYCLES+3 from first raw lock sample to ready.
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  seq_state_e    state;
  logic [CW-1:0] state_cnt;
  logic [RW-1:0] tmo_cnt;
  logic          lock_s;
  logic          retry_exhausted;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
  // The timeout now being taken is the MAX_RETRIES-th in a row.
  assign retry_exhausted = (tmo_cnt == RETRY_LAST);
  assign fail            = (state == FAIL);
`else
  assign retry_exhausted = 1'b0;
  assign fail            = 1'b0;
`endif

  // Outputs decode the state register directly so core_rst and ready
  // switch in the same cycle as the state does.
  assign pll_rst  = (state == RESET_HOLD) || (state == FAIL);
  assign core_rst = (state != RUN);
  assign ready    = (state == RUN);

  // Sequencer FSM with its shared state counter, timeout and relock counters.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state        <= RESET_HOLD;
      state_cnt    <= '0;
      tmo_cnt      <= '0;
      relock_count <= 8'd0;
    end else begin
      case (state)
        RESET_HOLD: begin
          if (state_cnt == HOLD_LAST) begin
            state     <= WAIT_LOCK;
            state_cnt <= '0;
          end else begin
            state_cnt <= state_cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            state     <= STABLE;
            state_cnt <= '0;
          end else if (state_cnt == TMO_LAST) begin
            state        <= retry_exhausted ? FAIL : RESET_HOLD;
            state_cnt    <= '0;
            relock_count <= sat_inc8(relock_count);
            if (tmo_cnt != RETRY_MAX) tmo_cnt <= tmo_cnt + 1'b1;
          end else begin
            state_cnt <= state_cnt + 1'b1;
          end
        end

        STABLE: begin
          if (!lock_s) begin
            // Lock dropped before qualifying: restart the timeout window.
            state     <= WAIT_LOCK;
            state_cnt <= '0;
          end else if (state_cnt == STABLE_LAST) begin
            state     <= RUN;
            state_cnt <= '0;
            tmo_cnt   <= '0;
          end else begin
            state_cnt <= state_cnt + 1'b1;
          end
        end

        RUN: begin
          if (!lock_s) begin
            state        <= RESET_HOLD;
            state_cnt    <= '0;
            relock_count <= sat_inc8(relock_count);
          end
        end

        FAIL: begin
          state <= FAIL;
        end

        default: begin
          state     <= RESET_HOLD;
          state_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small parameters.
// Honours PLL_SEQ_RETRY_LIMIT_EN the same way the design does.
module tb_pll_reset_sequencer;

  localparam int H = 4;   // reset hold cycles
  localparam int S = 8;   // lock stable cycles
  localparam int T = 32;  // lock timeout cycles
  localparam int R = 2;   // max retries

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int P_HOLD = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, core_rst, ready, fail;
  logic [7:0] relock_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: phase, time spent in phase, counters, sync pipe.
  int m_phase, m_elapsed, m_relock, m_tmo;
  bit m_sync [2];

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (H),
    .LOCK_STABLE_CYCLES  (S),
    .LOCK_TIMEOUT_CYCLES (T),
    .MAX_RETRIES         (R)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .core_rst     (core_rst),
    .ready        (ready),
    .fail         (fail),
    .relock_count (relock_count)
  );

  task automatic model_reset();
    m_phase   = P_HOLD;
    m_elapsed = 0;
    m_relock  = 0;
    m_tmo     = 0;
    m_sync[0] = 1'b0;
    m_sync[1] = 1'b0;
  endtask

  // Advance the model by one refclk edge using the pre-edge synced lock.
  // Stable qualification takes S+1 edges after the WAIT_LOCK detect edge,
  // so raw sample -> ready is 2 (sync) + 1 (detect) + S+1 - 1 = S+3 edges later.
  task automatic model_step();
    bit ls;
    ls = m_sync[1];
    case (m_phase)
      P_HOLD: begin
        m_elapsed++;
        if (m_elapsed == H) begin m_phase = P_WAIT; m_elapsed = 0; end
      end
      P_WAIT: begin
        if (ls) begin
          m_phase = P_STABLE; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == T) begin
            m_elapsed = 0;
            if (m_relock < 255) m_relock++;
            m_tmo++;
            m_phase = (RETRY_EN && m_tmo >= R) ? P_FAIL : P_HOLD;
          end
        end
      end
      P_STABLE: begin
        if (!ls) begin
          m_phase = P_WAIT; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == S + 1) begin m_phase = P_RUN; m_elapsed = 0; m_tmo = 0; end
        end
      end
      P_RUN: begin
        if (!ls) begin
          m_phase = P_HOLD; m_elapsed = 0;
          if (m_relock < 255) m_relock++;
        end
      end
      default: ;
    endcase
    m_sync[1] = m_sync[0];
    m_sync[0] = pll_locked;
  endtask

  // One refclk edge; outputs compared with the model on the falling edge.
  task automatic cycle();
    logic [11:0] exp_v, act_v;
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    exp_v = {(m_phase == P_HOLD) || (m_phase == P_FAIL), m_phase != P_RUN,
             m_phase == P_RUN, m_phase == P_FAIL, 8'(m_relock)};
    act_v = {pll_rst, core_rst, ready, fail, relock_count};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_compare t=%0t: got %b expected %b", $time, act_v, exp_v);
    end
  endtask

  // Pulse rst from a falling edge; outputs must reach reset values at once.
  task automatic do_reset(input string name);
    @(negedge refclk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({pll_rst, core_rst, ready, fail, relock_count} !== 12'b1100_0000_0000) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name,
               {pll_rst, core_rst, ready, fail, relock_count}, 12'b1100_0000_0000);
    end
    model_reset();
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int max_cyc, input string name, output int n);
    n = 0;
    while (!ready && n < max_cyc) begin
      cycle();
      n++;
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: ready=%b after %0d cycles, required 1", name, ready, n);
    end
  endtask

  task automatic test_reset();
    pll_locked = 1'b0;
    do_reset("reset_values");
  endtask

  // Lock high from release: pll_rst must be high for exactly H cycles.
  task automatic test_power_up();
    int hi, n;
    pll_locked = 1'b1;
    do_reset("reset_power_up");
    #1;
    hi = pll_rst ? 1 : 0;
    for (int i = 0; i < 20 && pll_rst; i++) begin
      cycle();
      if (pll_rst) hi++;
    end
    n_checks++;
    if (hi !== H) begin
      n_fail++;
      $display("FAIL power_up_pll_rst_len: got %0d cycles expected %0d", hi, H);
    end
    wait_ready(40, "power_up_ready", n);
  endtask

  // Lock arriving during WAIT_LOCK: ready exactly S+3 edges after first sample.
  task automatic test_lock_latency();
    int n;
    pll_locked = 1'b0;
    do_reset("reset_latency");
    repeat (H + 3) cycle();
    pll_locked = 1'b1;
    wait_ready(40, "latency_ready", n);
    n_checks++;
    if (n - 1 !== S + 3) begin
      n_fail++;
      $display("FAIL ready_latency: got %0d expected %0d", n - 1, S + 3);
    end
  endtask

  // One-cycle lock glitch in STABLE: requalify from scratch, no relock count.
  task automatic test_stable_glitch();
    int n;
    pll_locked = 1'b0;
    do_reset("reset_glitch");
    repeat (H + 3) cycle();
    pll_locked = 1'b1;
    repeat (4) cycle();
    pll_locked = 1'b0;
    cycle();
    pll_locked = 1'b1;
    wait_ready(40, "glitch_ready", n);
    n_checks++;
    if (n - 1 !== S + 3) begin
      n_fail++;
      $display("FAIL glitch_requalify: got %0d expected %0d", n - 1, S + 3);
    end
    n_checks++;
    if (relock_count !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch_relock: got %0d expected 0", relock_count);
    end
  endtask

  // Lock loss in RUN: ready drops within 3 cycles, H cycles of pll_rst, count 1.
  task automatic test_lock_loss();
    int n, drop_n, hi;
    pll_locked = 1'b1;
    do_reset("reset_lock_loss");
    wait_ready(40, "loss_ready", n);
    pll_locked = 1'b0;
    drop_n = -1;
    hi = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (!ready && drop_n < 0) drop_n = i;
      if (pll_rst) hi++;
    end
    n_checks++;
    if (drop_n < 1 || drop_n > 3) begin
      n_fail++;
      $display("FAIL loss_ready_drop: got %0d cycles expected 1..3", drop_n);
    end
    n_checks++;
    if (hi !== H) begin
      n_fail++;
      $display("FAIL loss_pll_rst_len: got %0d expected %0d", hi, H);
    end
    n_checks++;
    if (relock_count !== 8'd1) begin
      n_fail++;
      $display("FAIL loss_relock: got %0d expected 1", relock_count);
    end
  endtask

  // Lock never arrives: bounded retries into FAIL, or saturating endless retry.
  task automatic test_timeout();
    pll_locked = 1'b0;
    do_reset("reset_timeout");
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    repeat (R * (H + T) + 10) cycle();
    n_checks++;
    if ({fail, pll_rst, core_rst, ready, relock_count} !== {4'b1110, 8'd2}) begin
      n_fail++;
      $display("FAIL timeout_fail_state: got %b expected %b",
               {fail, pll_rst, core_rst, ready, relock_count}, {4'b1110, 8'd2});
    end
    pll_locked = 1'b1;
    repeat (60) cycle();
    n_checks++;
    if ({fail, pll_rst, ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL timeout_fail_sticky: got %b expected 110", {fail, pll_rst, ready});
    end
`else
    repeat (256 * (H + T) + 10) cycle();
    n_checks++;
    if ({fail, relock_count} !== {1'b0, 8'd255}) begin
      n_fail++;
      $display("FAIL timeout_saturate: got fail=%b count=%0d expected fail=0 count=255",
               fail, relock_count);
    end
`endif
  endtask

  // rst in RUN and in WAIT_LOCK aborts at once; the full sequence repeats.
  task automatic test_rst_abort();
    int n;
    pll_locked = 1'b1;
    do_reset("reset_abort_pre");
    wait_ready(40, "abort_ready1", n);
    do_reset("abort_in_run");
    wait_ready(40, "abort_ready2", n);
    n_checks++;
    if (n - 1 !== H + S + 1) begin
      n_fail++;
      $display("FAIL abort_resequence: got %0d expected %0d", n - 1, H + S + 1);
    end
    pll_locked = 1'b0;
    do_reset("reset_abort_wait");
    repeat (H + 6) cycle();
    do_reset("abort_in_wait_lock");
    pll_locked = 1'b1;
    wait_ready(40, "abort_ready3", n);
  endtask

  // Random lock waveforms with long and short runs against the model.
  task automatic test_random();
    int run_left;
    pll_locked = 1'b1;
    do_reset("reset_random");
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        if ($urandom_range(0, 2) != 0) begin
          pll_locked = 1'b1; run_left = $urandom_range(1, 60);
        end else begin
          pll_locked = 1'b0; run_left = $urandom_range(1, 45);
        end
      end
      run_left--;
      cycle();
      if (m_phase == P_FAIL && $urandom_range(0, 19) == 0) do_reset("reset_random_fail");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_power_up();
    test_lock_latency();
    test_stable_glitch();
    test_lock_loss();
    test_timeout();
    test_rst_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
